dec_ins: RTL and testbench

Clocked decode stage of the multi-cycle MIPS core, directly downstream of instruction fetch. Accepts a fetched instruction word over a valid/ready handshake and splits it into fields. Reads the rs/rt operands from the register file through the shared read port, builds the extended immediate, and presents a decoded bundle to execute over a second valid/ready handshake.

---
 rtl/dec_ins_pkg.sv | 92 +++++++++
 rtl/dec_ins_imm_ext.sv | 25 ++
 rtl/dec_ins.sv | 132 +++++++++++++
 tb/tb_dec_ins.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_ins_pkg.sv
// dec_ins_pkg: shared definitions for the decode stage.
//   - WORD_SIZE_DEF  : default datapath width
//   - OP_* / FN_*    : MIPS opcode and R-type funct encodings
//   - dec_state_t    : decode FSM state encoding
//   - helper functions classifying an instruction (legality, write-back,
//     destination register)
package dec_ins_pkg;

  localparam int WORD_SIZE_DEF = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_RS   = 3'd1,
    RD_RT   = 3'd2,
    WAIT_RT = 3'd3,
    VALID   = 3'd4
  } dec_state_t;

  function automatic logic funct_known(input logic [5:0] funct);
    case (funct)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
      FN_SLT, FN_SLTU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_RTYPE: return funct_known(funct);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic writes_reg(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_RTYPE: return funct_known(funct) && (funct != FN_JR);
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU,
      OP_LUI, OP_LW, OP_JAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // rd for R-type, rt for I-type, link register for JAL, 0 for J and unknowns
  function automatic logic [4:0] dest_reg(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rd);
    case (op)
      OP_RTYPE: return rd;
      OP_JAL:   return 5'd31;
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
      OP_XORI, OP_LUI, OP_LW, OP_SW: return rt;
      default:  return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/dec_ins_imm_ext.sv
// imm_ext: combinational immediate extension for the decode stage.
//   op      in  6          opcode
//   imm     in  16         ir[15:0]
//   dec_imm out WORD_SIZE  zero-extended (ANDI/ORI/XORI), LUI-shifted, or
//                          sign-extended (everything else)
module imm_ext
  import dec_ins_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic [5:0]           op,
  input  logic [15:0]          imm,
  output logic [WORD_SIZE-1:0] dec_imm
);

  always_comb begin
    dec_imm = '0;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: dec_imm = {{(WORD_SIZE-16){1'b0}}, imm};
      OP_LUI:                   dec_imm = {{(WORD_SIZE-32){1'b0}}, imm, 16'h0000};
      default:                  dec_imm = {{(WORD_SIZE-16){imm[15]}}, imm};
    endcase
  end

endmodule

// File: rtl/dec_ins.sv
// dec_ins: decode stage of the multi-cycle MIPS core.
// Accepts an instruction over ir_valid/ir_ready, reads rs then rt through the
// shared register-file read port (one-cycle read latency), and presents the
// decoded bundle over dec_valid/dec_ready.
//   clk, rst                 clock, async active-high reset
//   ir_valid/ir_ready/ir_reg fetch handshake and instruction word
//   reg_on/reg_w/reg_addr    register-file port control (read only)
//   reg_data_out             register-file read data
//   dec_valid/dec_ready      execute handshake
//   dec_*                    decoded bundle
// Optional macro DEC_ILLEGAL_TRAP_EN adds output dec_illegal.
//
// state   | meaning
// IDLE    | waiting for an instruction, ir_ready=1
// RD_RS   | rs index on the read port
// RD_RT   | rt index on the read port, rs data captured at exit
// WAIT_RT | port idle, rt data captured at exit
// VALID   | bundle presented, held until dec_ready
module dec_ins
  import dec_ins_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ir_valid,
  output logic                 ir_ready,
  input  logic [WORD_SIZE-1:0] ir_reg,
  output logic                 reg_on,
  output logic                 reg_w,
  output logic [WORD_SIZE-1:0] reg_addr,
  input  logic [WORD_SIZE-1:0] reg_data_out,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [5:0]           dec_op,
  output logic [5:0]           dec_funct,
  output logic [4:0]           dec_shamt,
  output logic [4:0]           dec_dst,
  output logic                 dec_wb,
  output logic [WORD_SIZE-1:0] dec_a,
  output logic [WORD_SIZE-1:0] dec_b,
  output logic [WORD_SIZE-1:0] dec_imm,
`ifdef DEC_ILLEGAL_TRAP_EN
  output logic                 dec_illegal,
`endif
  output logic [25:0]          dec_jtarget
);

  dec_state_t           state;
  logic [31:0]          ir_q;
  logic                 accept;
  logic [WORD_SIZE-1:0] imm_c;
  logic                 wb_c;

  assign reg_w    = 1'b0;
  assign ir_ready = (state == IDLE) || ((state == VALID) && dec_ready);
  assign accept   = ir_ready && ir_valid;

  imm_ext #(.WORD_SIZE(WORD_SIZE)) u_imm_ext (
    .op      (ir_q[31:26]),
    .imm     (ir_q[15:0]),
    .dec_imm (imm_c)
  );

  assign wb_c = writes_reg(ir_q[31:26], ir_q[5:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ir_q        <= '0;
      reg_on      <= 1'b0;
      reg_addr    <= '0;
      dec_valid   <= 1'b0;
      dec_op      <= '0;
      dec_funct   <= '0;
      dec_shamt   <= '0;
      dec_dst     <= '0;
      dec_wb      <= 1'b0;
      dec_a       <= '0;
      dec_b       <= '0;
      dec_imm     <= '0;
      dec_jtarget <= '0;
`ifdef DEC_ILLEGAL_TRAP_EN
      dec_illegal <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, VALID: begin
          if (state == VALID && dec_ready) begin
            dec_valid <= 1'b0;
            state     <= IDLE;
          end
          // Accept overrides the IDLE return above when execute drains and
          // fetch offers the next word in the same cycle.
          if (accept) begin
            ir_q     <= ir_reg[31:0];
            reg_on   <= 1'b1;
            reg_addr <= WORD_SIZE'(ir_reg[25:21]);
            state    <= RD_RS;
          end
        end
        RD_RS: begin
          reg_addr <= WORD_SIZE'(ir_q[20:16]);
          state    <= RD_RT;
        end
        RD_RT: begin
          dec_a    <= (ir_q[25:21] == 5'd0) ? '0 : reg_data_out;
          reg_on   <= 1'b0;
          reg_addr <= '0;
          state    <= WAIT_RT;
        end
        WAIT_RT: begin
          dec_b       <= (ir_q[20:16] == 5'd0) ? '0 : reg_data_out;
          dec_op      <= ir_q[31:26];
          dec_funct   <= ir_q[5:0];
          dec_shamt   <= ir_q[10:6];
          dec_dst     <= dest_reg(ir_q[31:26], ir_q[20:16], ir_q[15:11]);
          dec_wb      <= wb_c;
          dec_imm     <= imm_c;
          dec_jtarget <= ir_q[25:0];
`ifdef DEC_ILLEGAL_TRAP_EN
          dec_illegal <= !is_legal(ir_q[31:26], ir_q[5:0]);
`endif
          dec_valid   <= 1'b1;
          state       <= VALID;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_ins.sv
module tb_dec_ins;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_reg;
  logic        reg_on;
  logic        reg_w;
  logic [31:0] reg_addr;
  logic [31:0] reg_data_out;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  dec_op;
  logic [5:0]  dec_funct;
  logic [4:0]  dec_shamt;
  logic [4:0]  dec_dst;
  logic        dec_wb;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [31:0] dec_imm;
  logic [25:0] dec_jtarget;
`ifdef DEC_ILLEGAL_TRAP_EN
  logic        dec_illegal;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  // Register file: one-cycle read latency, garbage when the port is idle.
  // r0 holds garbage on purpose so the decoder's zero forcing is visible.
  always @(posedge clk) reg_data_out <= reg_on ? rf[reg_addr[4:0]] : 32'hBAD0_0BAD;

  dec_ins dut (
    .clk          (clk),
    .rst          (rst),
    .ir_valid     (ir_valid),
    .ir_ready     (ir_ready),
    .ir_reg       (ir_reg),
    .reg_on       (reg_on),
    .reg_w        (reg_w),
    .reg_addr     (reg_addr),
    .reg_data_out (reg_data_out),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_op       (dec_op),
    .dec_funct    (dec_funct),
    .dec_shamt    (dec_shamt),
    .dec_dst      (dec_dst),
    .dec_wb       (dec_wb),
    .dec_a        (dec_a),
    .dec_b        (dec_b),
    .dec_imm      (dec_imm),
`ifdef DEC_ILLEGAL_TRAP_EN
    .dec_illegal  (dec_illegal),
`endif
    .dec_jtarget  (dec_jtarget)
  );

  typedef struct {
    logic [31:0] ir;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  dst;
    logic        wb;
    logic        ill;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ir_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ir_ready_wait", 32'(ir_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    wait_ready();
    ir_valid = 1'b1;
    ir_reg   = v.ir;
    @(posedge clk);
    #1;
    ir_valid = 1'b0;
    ir_reg   = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rs_on",    32'(reg_on),    32'd1);
    chk("rs_addr",  reg_addr,       32'(v.ir[25:21]));
    chk("valid_c1", 32'(dec_valid), 32'd0);
    @(negedge clk);
    chk("rt_on",    32'(reg_on),    32'd1);
    chk("rt_addr",  reg_addr,       32'(v.ir[20:16]));
    chk("valid_c2", 32'(dec_valid), 32'd0);
    @(negedge clk);
    chk("off_on",   32'(reg_on),    32'd0);
    chk("valid_c3", 32'(dec_valid), 32'd0);
    @(negedge clk);
    chk("valid",    32'(dec_valid), 32'd1);
    chk("op",       32'(dec_op),    32'(v.op));
    chk("funct",    32'(dec_funct), 32'(v.funct));
    chk("shamt",    32'(dec_shamt), 32'(v.shamt));
    chk("dst",      32'(dec_dst),   32'(v.dst));
    chk("wb",       32'(dec_wb),    32'(v.wb));
    chk("a",        dec_a,          v.a);
    chk("b",        dec_b,          v.b);
    chk("imm",      dec_imm,        v.imm);
    chk("jtarget",  32'(dec_jtarget), 32'(v.ir[25:0]));
    chk("reg_w",    32'(reg_w),     32'd0);
`ifdef DEC_ILLEGAL_TRAP_EN
    chk("illegal",  32'(dec_illegal), 32'(v.ill));
`endif
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    chk("drain_valid", 32'(dec_valid), 32'd0);
    chk("drain_ready", 32'(ir_ready),  32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //           ir            op     funct  sh     dst    wb    ill   a              b              imm
    vecs[0]  = '{32'h00221821, 6'h00, 6'h21, 5'd0,  5'd3,  1'b1, 1'b0, 32'd5,         32'd7,         32'h0000_1821};
    vecs[1]  = '{32'h34048000, 6'h0D, 6'h00, 5'd0,  5'd4,  1'b1, 1'b0, 32'd0,         32'hA000_0004, 32'h0000_8000};
    vecs[2]  = '{32'h20A5FFFF, 6'h08, 6'h3F, 5'd31, 5'd5,  1'b1, 1'b0, 32'hA000_0005, 32'hA000_0005, 32'hFFFF_FFFF};
    vecs[3]  = '{32'h3C011234, 6'h0F, 6'h34, 5'd8,  5'd1,  1'b1, 1'b0, 32'd0,         32'd5,         32'h1234_0000};
    vecs[4]  = '{32'hFC000000, 6'h3F, 6'h00, 5'd0,  5'd0,  1'b0, 1'b1, 32'd0,         32'd0,         32'h0000_0000};
    vecs[5]  = '{32'h0C000010, 6'h03, 6'h10, 5'd0,  5'd31, 1'b1, 1'b0, 32'd0,         32'd0,         32'h0000_0010};
    vecs[6]  = '{32'hAC430004, 6'h2B, 6'h04, 5'd0,  5'd3,  1'b0, 1'b0, 32'd7,         32'hA000_0003, 32'h0000_0004};
    vecs[7]  = '{32'h03E00008, 6'h00, 6'h08, 5'd0,  5'd0,  1'b0, 1'b0, 32'hA000_001F, 32'd0,         32'h0000_0008};
    vecs[8]  = '{32'h3043FFFF, 6'h0C, 6'h3F, 5'd31, 5'd3,  1'b1, 1'b0, 32'd7,         32'hA000_0003, 32'h0000_FFFF};
    vecs[9]  = '{32'h0000003F, 6'h00, 6'h3F, 5'd0,  5'd0,  1'b0, 1'b1, 32'd0,         32'd0,         32'h0000_003F};
    vecs[10] = '{32'h00021080, 6'h00, 6'h00, 5'd2,  5'd2,  1'b1, 1'b0, 32'd0,         32'd7,         32'h0000_1080};
    vecs[11] = '{32'h1022FFFE, 6'h04, 6'h3E, 5'd31, 5'd2,  1'b0, 1'b0, 32'd5,         32'd7,         32'hFFFF_FFFE};

    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 | 32'(i);
    rf[0] = 32'hDEAD_BEEF;
    rf[1] = 32'd5;
    rf[2] = 32'd7;

    rst       = 1'b1;
    ir_valid  = 1'b0;
    ir_reg    = '0;
    dec_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ir_ready",  32'(ir_ready),  32'd1);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_reg_on",    32'(reg_on),    32'd0);
    chk("rst_reg_w",     32'(reg_w),     32'd0);
    chk("rst_reg_addr",  reg_addr,       32'd0);
    chk("rst_dec_imm",   dec_imm,        32'd0);
    chk("rst_dec_a",     dec_a,          32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Backpressure: bundle held, new ir_valid ignored, then same-cycle handoff.
    wait_ready();
    ir_valid = 1'b1;
    ir_reg   = 32'h00221821;
    @(posedge clk);
    #1 ir_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_valid", 32'(dec_valid), 32'd1);
    for (int c = 0; c < 3; c++) begin
      ir_valid = 1'b1;
      ir_reg   = 32'h1022FFFE;
      #1;
      chk("bp_ir_ready", 32'(ir_ready),  32'd0);
      chk("bp_hold_v",   32'(dec_valid), 32'd1);
      chk("bp_hold_a",   dec_a,          32'd5);
      chk("bp_hold_b",   dec_b,          32'd7);
      chk("bp_hold_dst", 32'(dec_dst),   32'd3);
      @(negedge clk);
    end
    chk("bp_still_op", 32'(dec_funct), 32'h21);
    dec_ready = 1'b1;
    #1;
    chk("bp_handoff_ready", 32'(ir_ready), 32'd1);
    @(posedge clk);
    #1;
    ir_valid  = 1'b0;
    dec_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_v0",   32'(dec_valid), 32'd0);
    chk("bp_next_rs",   reg_addr,       32'd1);
    repeat (2) @(negedge clk);
    chk("bp_next_v0b",  32'(dec_valid), 32'd0);
    @(negedge clk);
    chk("bp_next_v1",   32'(dec_valid), 32'd1);
    chk("bp_next_op",   32'(dec_op),    32'h04);
    chk("bp_next_imm",  dec_imm,        32'hFFFF_FFFE);
    chk("bp_next_a",    dec_a,          32'd5);
    chk("bp_next_b",    dec_b,          32'd7);
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;

    // Reset while in WAIT_RT aborts the instruction immediately.
    wait_ready();
    ir_valid = 1'b1;
    ir_reg   = 32'h00221821;
    @(posedge clk);
    #1 ir_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(dec_valid), 32'd0);
    chk("mid_rst_ready", 32'(ir_ready),  32'd1);
    chk("mid_rst_reg_on", 32'(reg_on),   32'd0);
    chk("mid_rst_dec_a", dec_a,          32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_no_bundle", 32'(dec_valid), 32'd0);
    end

    // Decode still works after the aborted instruction.
    run_vec(vecs[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
